// File: rtl/data_mem_resp_if.sv
// Load/store port between the memory-access stage (master) and the data-memory responder (slave).
interface data_mem_resp_if #(
  parameter int unsigned wd_regs_p = 32
);
  logic [wd_regs_p-1:0] i_mem_rd_addr;
  logic [wd_regs_p-1:0] o_mem_rd_data;
  logic                 o_rd_err;
  logic                 i_mem_wr_en;
  logic [wd_regs_p-1:0] i_mem_wr_addr;
  logic [wd_regs_p-1:0] i_mem_wr_data;
  logic                 o_wr_err;
  logic [31:0]          o_wr_count;

  modport master (
    output i_mem_rd_addr, i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
    input  o_mem_rd_data, o_rd_err, o_wr_err, o_wr_count
  );

  modport slave (
    input  i_mem_rd_addr, i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
    output o_mem_rd_data, o_rd_err, o_wr_err, o_wr_count
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: fixed-latency read pipeline, checked word writes, saturating write counter.
// Optional macro DMEM_FWD_EN: same-cycle accepted write data is forwarded into the read (default: read-before-write).
module data_mem_resp #(
  parameter int unsigned wd_regs_p    = 32,
  parameter int unsigned depth_p      = 1024,
  parameter int unsigned rd_latency_p = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_resp_if.slave bus
);

  localparam int unsigned idx_w_lp = $clog2(depth_p);
  localparam int unsigned hi_lp    = idx_w_lp + 2;
  localparam int unsigned cnt_w_lp = 32;

  if (rd_latency_p < 1 || rd_latency_p > 4) begin : g_bad_latency
    $error("data_mem_resp: rd_latency_p must be in 1..4");
  end
  if (depth_p < 4 || (depth_p & (depth_p - 1)) != 0) begin : g_bad_depth
    $error("data_mem_resp: depth_p must be a power of 2 and >= 4");
  end
  if (wd_regs_p <= hi_lp) begin : g_bad_width
    $error("data_mem_resp: wd_regs_p too narrow for depth_p");
  end

  logic [wd_regs_p-1:0] mem_q [depth_p];

  logic [idx_w_lp-1:0]  rd_idx, wr_idx;
  logic                 rd_oor, rd_mis, wr_oor, wr_mis;
  logic                 wr_ok, wr_rej;
  logic [wd_regs_p-1:0] rd_word;

  logic [wd_regs_p-1:0] data_q [rd_latency_p];
  logic [wd_regs_p-1:0] data_d [rd_latency_p];
  logic                 err_q  [rd_latency_p];
  logic                 err_d  [rd_latency_p];

  logic                 wr_err_q, wr_err_d;
  logic [cnt_w_lp-1:0]  wr_count_q, wr_count_d;

  // Address decode: word index, range and alignment for both ports
  always_comb begin
    rd_idx = bus.i_mem_rd_addr[hi_lp-1:2];
    rd_oor = |bus.i_mem_rd_addr[wd_regs_p-1:hi_lp];
    rd_mis = |bus.i_mem_rd_addr[1:0];
    wr_idx = bus.i_mem_wr_addr[hi_lp-1:2];
    wr_oor = |bus.i_mem_wr_addr[wd_regs_p-1:hi_lp];
    wr_mis = |bus.i_mem_wr_addr[1:0];
    wr_ok  = bus.i_mem_wr_en & ~wr_oor & ~wr_mis;
    wr_rej = bus.i_mem_wr_en & ~wr_ok;
  end

  // Stage 0 captures storage data; later stages only delay it
  always_comb begin
    rd_word = mem_q[rd_idx];
`ifdef DMEM_FWD_EN
    if (wr_ok && (wr_idx == rd_idx)) rd_word = bus.i_mem_wr_data;
`endif
    data_d[0] = rd_oor ? '0 : rd_word;
    err_d[0]  = rd_oor | rd_mis;
    for (int unsigned i = 1; i < rd_latency_p; i++) begin
      data_d[i] = data_q[i-1];
      err_d[i]  = err_q[i-1];
    end
  end

  always_comb begin
    wr_err_d   = wr_rej;
    wr_count_d = wr_count_q;
    if (wr_ok && (wr_count_q != '1)) wr_count_d = wr_count_q + cnt_w_lp'(1);
  end

  // Storage is never cleared; a write on an edge seen while in reset is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (wr_ok) begin
      mem_q[wr_idx] <= bus.i_mem_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < rd_latency_p; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
      wr_err_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < rd_latency_p; i++) begin
        data_q[i] <= data_d[i];
        err_q[i]  <= err_d[i];
      end
      wr_err_q   <= wr_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.o_mem_rd_data = data_q[rd_latency_p-1];
  assign bus.o_rd_err      = err_q[rd_latency_p-1];
  assign bus.o_wr_err      = wr_err_q;
  assign bus.o_wr_count    = wr_count_q;

endmodule
